// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage and its register file.
//   result_src_t : writeback result select encoding (11 is reserved and
//                  produces a zero result)
//   XLEN         : architectural register width
//   REG_IDX_W    : register index width
//   RDW_RSVD_BIT : position of the reserved bit in the destination index
package wb_pkg;
    localparam int XLEN         = 32;
    localparam int REG_IDX_W    = 5;
    localparam int RDW_RSVD_BIT = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;
endpackage

// File: rtl/regfile.sv
// Architectural register file with NUM_RD asynchronous read ports.
//   clk, rst_n : clock, async active-low reset (clears every register)
//   we         : write commit, already qualified by the caller
//   waddr/wdata: write index and value, stored on the rising edge
//   raddr      : packed read addresses, one per read port
//   rdata      : packed read data; x0 reads 0, and a commit pending this
//                cycle to the same index is bypassed onto the port
module regfile
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_COUNT  = 32,
    parameter int NUM_RD     = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  we,
    input  logic [REG_IDX_W-1:0]                  waddr,
    input  logic [DATA_WIDTH-1:0]                 wdata,
    input  logic [NUM_RD-1:0][REG_IDX_W-1:0]      raddr,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]     rdata
);
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 check comes first so a bypass aimed at x0 can never leak through.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign rdata[p] = (raddr[p] == '0)              ? '0    :
                          (we && waddr == raddr[p])     ? wdata :
                                                          regs[raddr[p]];
    end
endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, register commit and committed-write count.
//   clk, rst_n        : clock, async active-low reset
//   RegWriteW         : write enable from MEM/WB
//   ResultSrcW        : 00 ALU, 01 load data, 10 PC+4, 11 zero
//   ALUOutW/ReadDataW/PCPlus4W : writeback candidates
//   RDW               : destination index, bit 5 reserved (suppresses write)
//   A1D/A2D, RD1D/RD2D: decode read ports with same-cycle bypass
//   ResultW           : selected writeback value (also forwarding source)
//   WbCount           : committed-write counter, wraps silently
// Optional build macro REGFILE_DEBUG_PORT_EN adds DbgA0 (live view of a0)
// and a third read port DbgAddr/DbgData, both with the same bypass rule.
module writeback_regfile
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_COUNT  = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   RegWriteW,
    input  logic [1:0]             ResultSrcW,
    input  logic [DATA_WIDTH-1:0]  ALUOutW,
    input  logic [DATA_WIDTH-1:0]  ReadDataW,
    input  logic [REG_IDX_W:0]     RDW,
    input  logic [DATA_WIDTH-1:0]  PCPlus4W,
    input  logic [REG_IDX_W-1:0]   A1D,
    input  logic [REG_IDX_W-1:0]   A2D,
    output logic [DATA_WIDTH-1:0]  RD1D,
    output logic [DATA_WIDTH-1:0]  RD2D,
    output logic [DATA_WIDTH-1:0]  ResultW,
`ifdef REGFILE_DEBUG_PORT_EN
    output logic [DATA_WIDTH-1:0]  DbgA0,
    input  logic [REG_IDX_W-1:0]   DbgAddr,
    output logic [DATA_WIDTH-1:0]  DbgData,
`endif
    output logic [CNT_WIDTH-1:0]   WbCount
);
`ifdef REGFILE_DEBUG_PORT_EN
    localparam int NUM_RD = 4;
`else
    localparam int NUM_RD = 2;
`endif
    localparam logic [REG_IDX_W-1:0] A0_IDX = REG_IDX_W'(10);

    logic                                commit;
    logic [NUM_RD-1:0][REG_IDX_W-1:0]    raddr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rdata;

    always_comb begin
        ResultW = '0;
        case (ResultSrcW)
            RES_ALU: ResultW = ALUOutW;
            RES_MEM: ResultW = ReadDataW;
            RES_PC4: ResultW = PCPlus4W;
            default: ResultW = '0;
        endcase
    end

    // Writes to x0 and to reserved indices are dropped here, so neither
    // the storage nor the bypass path nor the counter ever sees them.
    assign commit = RegWriteW && !RDW[RDW_RSVD_BIT] && (RDW[REG_IDX_W-1:0] != '0);

    assign raddr[0] = A1D;
    assign raddr[1] = A2D;
    assign RD1D     = rdata[0];
    assign RD2D     = rdata[1];
`ifdef REGFILE_DEBUG_PORT_EN
    assign raddr[2] = DbgAddr;
    assign raddr[3] = A0_IDX;
    assign DbgData  = rdata[2];
    assign DbgA0    = rdata[3];
`endif

    regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .NUM_RD     (NUM_RD)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit),
        .waddr (RDW[REG_IDX_W-1:0]),
        .wdata (ResultW),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      WbCount <= '0;
        else if (commit) WbCount <= WbCount + CNT_WIDTH'(1);
    end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Writeback stage of the 5-stage RV32I pipeline; sits directly downstream of the MEM/WB pipeline register.
- Selects the writeback result from the ALU output, load data or PC+4, and commits it to the 32-entry architectural register file.
- Provides the two asynchronous read ports used by decode, with same-cycle write-to-read bypass.
- Counts committed register writes for performance and debug.

Parameters:
- DATA_WIDTH, 32, register and result width
- REG_COUNT, 32, number of architectural registers; the index is 5 bits
- CNT_WIDTH, 32, width of the committed-write counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- RegWriteW  in  1  write enable from MEM/WB
- ResultSrcW  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved
- ALUOutW  in  32  ALU result
- ReadDataW  in  32  load data
- RDW  in  6  destination register index; bit 5 reserved
- PCPlus4W  in  32  link value for JAL/JALR
- A1D  in  5  decode read address, port 1
- A2D  in  5  decode read address, port 2
- RD1D  out  32  read data, port 1
- RD2D  out  32  read data, port 2
- ResultW  out  32  selected writeback value, also used as the forwarding source to execute
- WbCount  out  CNT_WIDTH  number of committed writes

Behaviour:
- Reset:
  - rst_n low clears all 32 registers and WbCount to 0 immediately, independent of clk.
  - Outputs are combinational and therefore read 0 while reset is held, except ResultW, which follows its inputs.
  - Deassertion is synchronised externally.
  - If reset is asserted in the same cycle as a write, the write is lost.
- Result mux (combinational):
  - ResultW = ALUOutW when ResultSrcW=00, ReadDataW when 01, PCPlus4W when 10.
  - ResultSrcW=11 gives ResultW=0.
- Write commit:
  - On the rising clk edge with rst_n high, the write is committed when RegWriteW=1, RDW[5]=0 and RDW[4:0]!=0.
  - The commit stores ResultW into reg[RDW[4:0]] and increments WbCount by 1.
  - Latency is 1 edge.
- Suppressed writes:
  - RDW[4:0]=0 never writes; x0 always reads 0.
  - RDW[5]=1 is a reserved index: write suppressed, WbCount unchanged.
  - ResultSrcW=11 with RegWriteW=1 commits the value 0 and counts the write.
- Reads:
  - RDn = 0 when An=0.
  - Otherwise, if a write commit to the same index is pending this cycle, RDn = ResultW (bypass, so decode sees the value in the same cycle).
  - Otherwise RDn = reg[An].
  - Both ports may address the same register, and both bypass simultaneously.
- WbCount wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- The block has no stall or flush inputs; upstream kills an instruction by clearing RegWriteW.

Optional Feature:
- Macro: REGFILE_DEBUG_PORT_EN.
- Defined:
  - Adds output port DbgA0 (32), which equals reg[10] (a0) with the same bypass rule as the read ports.
  - Adds input port DbgAddr (5) and output port DbgData (32), forming a third asynchronous read port with the same bypass rule.
- Undefined: none of these ports exist and the logic is absent.

Decomposition:
- Package wb_pkg holds:
  - typedef enum logic [1:0] result_src_t {RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10}
  - localparams XLEN=32 and REG_IDX_W=5
  - the reserved RDW bit position 5
- One sub-module, regfile:
  - storage, x0 rule, read ports with bypass, and reset
  - the result mux and WbCount stay in the top module.

Test Plan:
- Reset mid-run:
  - Stimulus: write x5=0xDEADBEEF, then pulse rst_n low between clock edges.
  - Response: RD1D(A1D=5)=0 immediately; WbCount=0.
- Result mux and commit:
  - Stimulus: RegWriteW=1, RDW=3, ResultSrcW=00 with ALUOutW=0x11; then RDW=4, ResultSrcW=01 with ReadDataW=0x22; then RDW=1, ResultSrcW=10 with PCPlus4W=0x1004.
  - Response: x3=0x11, x4=0x22, x1=0x1004; WbCount=3.
- x0 and reserved index:
  - Stimulus: write 0x55 to RDW=0, then to RDW=6'b100011.
  - Response: x0 reads 0; x3 unchanged; WbCount unchanged.
- Bypass:
  - Stimulus: RegWriteW=1, RDW=7, ALUOutW=0xCAFE, A1D=A2D=7 in the same cycle.
  - Response: RD1D=RD2D=0xCAFE before the edge; registered value is 0xCAFE after the edge.
- Killed instruction:
  - Stimulus: RegWriteW=0, RDW=9, ALUOutW=0x77.
  - Response: x9 unchanged; WbCount unchanged.
- Counter wrap:
  - Stimulus: force WbCount=0xFFFFFFFF, then commit one write.
  - Response: WbCount=0.
  - With REGFILE_DEBUG_PORT_EN defined: after writing x10=0x2A, DbgA0=0x2A.
